address_sequencer: RTL and testbench
====================================

Name: address_sequencer

Overview:
- Parametrised successor to the combinational segment:offset calculator; generates bus addresses for V30MZ memory operands.
- Accepts one operand request (segment, base, index, displacement, factor mask, width) per handshake and emits one or two registered bus-address beats.
- Adds configurable address/offset widths, intra-segment offset wrap, 20-bit physical wrap, and splitting of odd-aligned word accesses into two byte beats.
- Sits between the execution-unit EA decode and the bus interface unit.

Parameters:
- ADDR_W, 20, physical address width; all physical sums are modulo 2^ADDR_W.
- OFFSET_W, 16, width of segment, base, index and displacement.
- SEG_SHIFT, 4, left shift applied to the segment.
- OFFSET_WRAP, 1, 1: effective offset truncated to OFFSET_W bits before the segment add; 0: full-width carry kept.
- SPLIT_ODD, 1, 1: odd-offset word access is issued as two byte beats; 0: always a single beat.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- factors  in  3  [2]=use base, [1]=use index, [0]=use displacement
- segment  in  OFFSET_W  segment register value
- base  in  OFFSET_W  base register value
- index  in  OFFSET_W  index register value
- displacement  in  OFFSET_W  displacement
- word  in  1  1 = 16-bit access, 0 = byte access
- bus_valid  out  1  beat valid
- bus_ready  in  1  beat consumed when bus_valid && bus_ready
- bus_address  out  ADDR_W  physical address of the beat
- bus_high  out  1  beat carries the high byte of a split word
- bus_last  out  1  final beat of the request
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset are fixed: single clock `clock`; reset `reset_n` is asynchronous, active-low.
- Reset values: state IDLE; bus_valid, bus_address, bus_high, bus_last and busy all 0. req_ready is forced to 0 while reset_n is low.
- Offset: off = sum of the inputs selected by factors. With OFFSET_WRAP=1 the sum is modulo 2^OFFSET_W; otherwise it is OFFSET_W+2 bits wide. factors=000 gives off=0.
- Physical address: phys(o) = ((segment << SEG_SHIFT) + o) mod 2^ADDR_W.
- Split condition: split = SPLIT_ODD && word && off[0].
- States:
  - IDLE: no beat pending.
  - FIRST: first or only beat pending.
  - SECOND: high-byte beat pending.
- req_ready = (state==IDLE) || (bus_valid && bus_ready && bus_last). This allows back-to-back requests with no bubble.
- On accept (registered, 1-cycle latency):
  - bus_valid=1, bus_address=phys(off), bus_high=0, bus_last=!split, state=FIRST.
  - Latch segment and off+1 (wrapped per OFFSET_WRAP) for the second beat.
- In FIRST with bus_ready && !bus_last: bus_address=phys(off+1), bus_high=1, bus_last=1, state=SECOND.
- Any state with bus_ready && bus_last:
  - If a new request is accepted in the same cycle, load it (state FIRST).
  - Otherwise bus_valid=0 and state=IDLE.
- While bus_valid && !bus_ready, all bus_* outputs hold stable. No request is accepted unless the final beat completes.
- Inputs are sampled only on the accept cycle; changes afterwards are ignored.
- Reset asserted mid-request: the request is dropped; outputs return to reset values immediately.
- Byte access at odd offset and word access at even offset produce a single beat.

Decomposition:
- Package address_sequencer_pkg holds:
  - state enum {IDLE, FIRST, SECOND};
  - localparam FACTOR_BASE=2, FACTOR_INDEX=1, FACTOR_DISP=0.
- One combinational sub-module, segment_offset_adder (segment, offset -> physical address, parametrised by ADDR_W/OFFSET_W/SEG_SHIFT). Instantiate it once, fed by a mux between off and the latched off+1.
- The offset sum and the FSM live in the top module.

Test Plan:
- Single byte: segment=0x1234, base=0x0010, disp=0x0005, factors=101, word=0, bus_ready=1 -> one beat at 0x12355, bus_last=1, bus_high=0; req_ready high the next cycle.
- Odd word split: segment=0x1000, index=0x0003, factors=010, word=1 -> beats 0x10003 (high=0, last=0) then 0x10004 (high=1, last=1); busy for 2 cycles.
- Offset wrap: segment=0x2000, base=0xFFFF, disp=0x0002, factors=101:
  - OFFSET_WRAP=1 -> 0x20001;
  - OFFSET_WRAP=0 -> 0x30001.
  - Also: odd word at off=0xFFFF -> beats 0x2FFFF then 0x20000.
- Physical wrap: segment=0xFFFF, disp=0x0010, factors=001 -> 0x00000.
- Backpressure and back-to-back: hold bus_ready=0 for 3 cycles -> address, high and last stay stable, req_ready=0. Release with a new req_valid pending -> next request's beat appears the cycle after, with no idle cycle.
- Reset mid-split: assert reset_n=0 while in SECOND -> bus_valid=0, bus_address=0, req_ready=0 at once. After release, the first request issues normally.

Source files
------------

// File: rtl/address_sequencer_pkg.sv
// Shared types and constants for the V30MZ operand address sequencer.
// Factor positions index the 3-bit factor mask carried with each request.
package address_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    localparam int FACTOR_BASE  = 2;
    localparam int FACTOR_INDEX = 1;
    localparam int FACTOR_DISP  = 0;

endpackage

// File: rtl/segment_offset_adder.sv
// Combinational segment:offset to physical address translation.
// The sum is formed wide enough for any parameter mix, then truncated to ADDR_W.
module segment_offset_adder #(
    parameter int ADDR_W    = 20,
    parameter int OFFSET_W  = 16,
    parameter int SEG_SHIFT = 4,
    parameter int OFF_IN_W  = OFFSET_W + 2
) (
    input  logic [OFFSET_W-1:0] segment,
    input  logic [OFF_IN_W-1:0] offset,
    output logic [ADDR_W-1:0]   phys_address
);

    localparam int WIDE_W = ADDR_W + OFFSET_W + OFF_IN_W + SEG_SHIFT;

    logic [WIDE_W-1:0] seg_ext;
    logic [WIDE_W-1:0] off_ext;
    logic [WIDE_W-1:0] sum;

    assign seg_ext      = WIDE_W'(segment) << SEG_SHIFT;
    assign off_ext      = WIDE_W'(offset);
    assign sum          = seg_ext + off_ext;
    assign phys_address = sum[ADDR_W-1:0];

endmodule

// File: rtl/address_sequencer.sv
// Operand address sequencer: one request in, one or two registered bus beats out.
// Odd-aligned word accesses are split into a low-byte beat and a high-byte beat.
module address_sequencer
    import address_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int OFFSET_W    = 16,
    parameter int SEG_SHIFT   = 4,
    parameter int OFFSET_WRAP = 1,
    parameter int SPLIT_ODD   = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          factors,
    input  logic [OFFSET_W-1:0] segment,
    input  logic [OFFSET_W-1:0] base,
    input  logic [OFFSET_W-1:0] index,
    input  logic [OFFSET_W-1:0] displacement,
    input  logic                word,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic [ADDR_W-1:0]   bus_address,
    output logic                bus_high,
    output logic                bus_last,
    output logic                busy
);

    localparam int SUM_W = OFFSET_W + 2;

    state_t              state, state_next;
    logic [SUM_W-1:0]    raw_sum, off, off_inc, off_plus1;
    logic [SUM_W-1:0]    off_hi_q;
    logic [OFFSET_W-1:0] seg_q;
    logic                split, accept, final_done;
    logic                valid_next, high_next, last_next;
    logic                addr_load, use_second;
    logic [OFFSET_W-1:0] adder_seg;
    logic [SUM_W-1:0]    adder_off;
    logic [ADDR_W-1:0]   phys;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        raw_sum = '0;
        if (factors[FACTOR_BASE])  raw_sum = raw_sum + SUM_W'(base);
        if (factors[FACTOR_INDEX]) raw_sum = raw_sum + SUM_W'(index);
        if (factors[FACTOR_DISP])  raw_sum = raw_sum + SUM_W'(displacement);
    end

    assign off       = (OFFSET_WRAP != 0) ? {2'b00, raw_sum[OFFSET_W-1:0]} : raw_sum;
    assign off_inc   = off + SUM_W'(1);
    assign off_plus1 = (OFFSET_WRAP != 0) ? {2'b00, off_inc[OFFSET_W-1:0]} : off_inc;
    assign split     = (SPLIT_ODD != 0) && word && off[0];

    assign final_done = bus_valid && bus_ready && bus_last;
    assign req_ready  = reset_n && ((state == IDLE) || final_done);
    assign accept     = req_valid && req_ready;
    assign busy       = (state != IDLE);

    // Single adder shared between the first beat (live inputs) and the high-byte beat.
    assign adder_seg = use_second ? seg_q    : segment;
    assign adder_off = use_second ? off_hi_q : off;

    segment_offset_adder #(
        .ADDR_W    (ADDR_W),
        .OFFSET_W  (OFFSET_W),
        .SEG_SHIFT (SEG_SHIFT),
        .OFF_IN_W  (SUM_W)
    ) u_adder (
        .segment      (adder_seg),
        .offset       (adder_off),
        .phys_address (phys)
    );

    always_comb begin
        state_next = state;
        valid_next = bus_valid;
        high_next  = bus_high;
        last_next  = bus_last;
        addr_load  = 1'b0;
        use_second = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = FIRST;
                    valid_next = 1'b1;
                    high_next  = 1'b0;
                    last_next  = !split;
                    addr_load  = 1'b1;
                end
            end
            FIRST, SECOND: begin
                if (bus_valid && bus_ready) begin
                    if (!bus_last) begin
                        state_next = SECOND;
                        high_next  = 1'b1;
                        last_next  = 1'b1;
                        addr_load  = 1'b1;
                        use_second = 1'b1;
                    end else if (accept) begin
                        state_next = FIRST;
                        valid_next = 1'b1;
                        high_next  = 1'b0;
                        last_next  = !split;
                        addr_load  = 1'b1;
                    end else begin
                        state_next = IDLE;
                        valid_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bus_valid   <= 1'b0;
            bus_high    <= 1'b0;
            bus_last    <= 1'b0;
            bus_address <= '0;
            seg_q       <= '0;
            off_hi_q    <= '0;
        end else begin
            state     <= state_next;
            bus_valid <= valid_next;
            bus_high  <= high_next;
            bus_last  <= last_next;
            if (addr_load) bus_address <= phys;
            if (accept) begin
                seg_q    <= segment;
                off_hi_q <= off_plus1;
            end
        end
    end

endmodule

// File: tb/tb_address_sequencer.sv
// Scoreboard bench: two sequencers (offset wrap on/off) share stimulus; a reference
// model pushes expected beats on accept and a negedge monitor pops and compares.
module tb_address_sequencer;

    typedef struct {
        logic [19:0] addr;
        logic        high;
        logic        last;
    } beat_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [2:0]  factors;
    logic [15:0] segment, base, index, displacement;
    logic        word;
    logic        bus_ready;
    logic [1:0]  req_ready, bus_valid, bus_high, bus_last, busy;
    logic [19:0] bus_address [2];

    int    checks = 0;
    int    errors = 0;
    int    ready_mode = 1;
    beat_t exp_q [2][$];
    bit    stalled [2];
    beat_t prev [2];

    always #5 clock = ~clock;

    address_sequencer #(.OFFSET_WRAP(1)) u_wrap (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready[0]),
        .factors(factors), .segment(segment), .base(base), .index(index),
        .displacement(displacement), .word(word), .bus_valid(bus_valid[0]),
        .bus_ready(bus_ready), .bus_address(bus_address[0]), .bus_high(bus_high[0]),
        .bus_last(bus_last[0]), .busy(busy[0])
    );

    address_sequencer #(.OFFSET_WRAP(0)) u_nowrap (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready[1]),
        .factors(factors), .segment(segment), .base(base), .index(index),
        .displacement(displacement), .word(word), .bus_valid(bus_valid[1]),
        .bus_ready(bus_ready), .bus_address(bus_address[1]), .bus_high(bus_high[1]),
        .bus_last(bus_last[1]), .busy(busy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] phys(input longint seg, input longint o);
        longint p;
        p = (seg * 16 + o) % 1048576;
        return p[19:0];
    endfunction

    // Reference model: beats from plain arithmetic; instance 0 wraps offsets, 1 does not.
    task automatic push_expected(input logic [2:0] f, input logic [15:0] seg, b, i, d,
                                 input logic w);
        for (int k = 0; k < 2; k++) begin
            longint off;
            longint off2;
            bit     split;
            beat_t  bt;
            off = 0;
            if (f[2]) off += longint'(b);
            if (f[1]) off += longint'(i);
            if (f[0]) off += longint'(d);
            if (k == 0) off = off % 65536;
            split   = w && (off % 2 == 1);
            bt.addr = phys(longint'(seg), off);
            bt.high = 1'b0;
            bt.last = !split;
            exp_q[k].push_back(bt);
            if (split) begin
                off2 = off + 1;
                if (k == 0) off2 = off2 % 65536;
                bt.addr = phys(longint'(seg), off2);
                bt.high = 1'b1;
                bt.last = 1'b1;
                exp_q[k].push_back(bt);
            end
        end
    endtask

    task automatic send(input logic [2:0] f, input logic [15:0] seg, b, i, d, input logic w);
        bit done;
        done         = 0;
        factors      = f;
        segment      = seg;
        base         = b;
        index        = i;
        displacement = d;
        word         = w;
        req_valid    = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clock);
            if (req_ready[0]) begin
                push_expected(f, seg, b, i, d, w);
                done = 1;
            end
        end
        if (!done) check("send_timeout", 0, 1);
        @(posedge clock);
        #1;
        req_valid    = 1'b0;
        factors      = 3'($urandom);
        segment      = 16'($urandom);
        base         = 16'($urandom);
        index        = 16'($urandom);
        displacement = 16'($urandom);
        word         = 1'($urandom);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int n = 0; n < 300 && !idle; n++) begin
            @(negedge clock);
            idle = !busy[0] && !busy[1] && exp_q[0].size() == 0 && exp_q[1].size() == 0;
        end
        check("drain_timeout", 32'(idle), 1);
        @(posedge clock);
        #1;
    endtask

    task automatic monitor_step(input int k);
        beat_t bt;
        if (!reset_n) begin
            stalled[k] = 0;
            return;
        end
        if (stalled[k]) begin
            check($sformatf("stall_valid[%0d]", k), 32'(bus_valid[k]), 1);
            check($sformatf("stall_addr[%0d]", k), 32'(bus_address[k]), 32'(prev[k].addr));
            check($sformatf("stall_high[%0d]", k), 32'(bus_high[k]), 32'(prev[k].high));
            check($sformatf("stall_last[%0d]", k), 32'(bus_last[k]), 32'(prev[k].last));
        end
        stalled[k] = 0;
        if (bus_valid[k]) begin
            if (bus_ready) begin
                if (exp_q[k].size() == 0) begin
                    check($sformatf("unexpected_beat[%0d]", k), 1, 0);
                end else begin
                    bt = exp_q[k].pop_front();
                    check($sformatf("beat_addr[%0d]", k), 32'(bus_address[k]), 32'(bt.addr));
                    check($sformatf("beat_high[%0d]", k), 32'(bus_high[k]), 32'(bt.high));
                    check($sformatf("beat_last[%0d]", k), 32'(bus_last[k]), 32'(bt.last));
                end
            end else begin
                stalled[k]   = 1;
                prev[k].addr = bus_address[k];
                prev[k].high = bus_high[k];
                prev[k].last = bus_last[k];
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) monitor_step(k);
        end
    end

    initial begin
        bus_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       bus_ready = ($urandom % 4) != 0;
                1:       bus_ready = 1'b1;
                default: bus_ready = 1'b0;
            endcase
        end
    end

    initial begin
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        factors      = '0;
        segment      = '0;
        base         = '0;
        index        = '0;
        displacement = '0;
        word         = 1'b0;

        repeat (3) @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_valid[%0d]", k), 32'(bus_valid[k]), 0);
            check($sformatf("rst_addr[%0d]", k), 32'(bus_address[k]), 0);
            check($sformatf("rst_busy[%0d]", k), 32'(busy[k]), 0);
            check($sformatf("rst_req_ready[%0d]", k), 32'(req_ready[k]), 0);
        end
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_req_ready", 32'(req_ready[0]), 1);
        @(posedge clock);
        #1;

        // Single byte beat
        send(3'b101, 16'h1234, 16'h0010, 16'h0000, 16'h0005, 1'b0);
        @(negedge clock);
        check("byte_addr", 32'(bus_address[0]), 32'h12355);
        check("byte_high", 32'(bus_high[0]), 0);
        check("byte_last", 32'(bus_last[0]), 1);
        @(negedge clock);
        check("byte_req_ready_after", 32'(req_ready[0]), 1);
        wait_idle();

        // Odd word split into two byte beats
        send(3'b010, 16'h1000, 16'h0000, 16'h0003, 16'h0000, 1'b1);
        @(negedge clock);
        check("split0_addr", 32'(bus_address[0]), 32'h10003);
        check("split0_last", 32'(bus_last[0]), 0);
        check("split0_busy", 32'(busy[0]), 1);
        @(negedge clock);
        check("split1_addr", 32'(bus_address[0]), 32'h10004);
        check("split1_high", 32'(bus_high[0]), 1);
        check("split1_busy", 32'(busy[0]), 1);
        @(negedge clock);
        check("split_done_busy", 32'(busy[0]), 0);
        wait_idle();

        // Offset wrap versus full-width carry
        send(3'b101, 16'h2000, 16'hFFFF, 16'h0000, 16'h0002, 1'b0);
        @(negedge clock);
        check("wrap_on_addr", 32'(bus_address[0]), 32'h20001);
        check("wrap_off_addr", 32'(bus_address[1]), 32'h30001);
        wait_idle();

        send(3'b001, 16'h2000, 16'h0000, 16'h0000, 16'hFFFF, 1'b1);
        @(negedge clock);
        check("wrap_split0_addr", 32'(bus_address[0]), 32'h2FFFF);
        @(negedge clock);
        check("wrap_split1_addr", 32'(bus_address[0]), 32'h20000);
        check("nowrap_split1_addr", 32'(bus_address[1]), 32'h30000);
        wait_idle();

        // Physical 20-bit wrap
        send(3'b001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0010, 1'b0);
        @(negedge clock);
        check("phys_wrap_addr", 32'(bus_address[0]), 32'h00000);
        wait_idle();

        // Backpressure, then back-to-back release
        ready_mode = 2;
        @(posedge clock);
        #1;
        send(3'b100, 16'h0100, 16'h0042, 16'h0000, 16'h0000, 1'b0);
        fork
            send(3'b011, 16'h0200, 16'h0000, 16'h0010, 16'h0004, 1'b0);
        join_none
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            check("bp_req_ready", 32'(req_ready[0]), 0);
            check("bp_addr", 32'(bus_address[0]), 32'h01042);
        end
        ready_mode = 1;
        @(negedge clock);
        check("bp_release_req_ready", 32'(req_ready[0]), 1);
        @(negedge clock);
        check("b2b_valid", 32'(bus_valid[0]), 1);
        check("b2b_addr", 32'(bus_address[0]), 32'h02014);
        wait_idle();

        // Reset while the high-byte beat is pending
        ready_mode = 2;
        @(posedge clock);
        #1;
        send(3'b010, 16'h1000, 16'h0000, 16'h0003, 16'h0000, 1'b1);
        @(negedge clock);
        ready_mode = 1;
        @(negedge clock);
        ready_mode = 2;
        @(negedge clock);
        check("mid_split_high", 32'(bus_high[0]), 1);
        check("mid_split_addr", 32'(bus_address[0]), 32'h10004);
        #2;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("midrst_valid[%0d]", k), 32'(bus_valid[k]), 0);
            check($sformatf("midrst_addr[%0d]", k), 32'(bus_address[k]), 0);
            check($sformatf("midrst_req_ready[%0d]", k), 32'(req_ready[k]), 0);
            check($sformatf("midrst_busy[%0d]", k), 32'(busy[k]), 0);
        end
        exp_q[0].delete();
        exp_q[1].delete();
        repeat (2) @(negedge clock);
        reset_n    = 1'b1;
        ready_mode = 1;
        @(posedge clock);
        #1;
        send(3'b101, 16'h1234, 16'h0010, 16'h0000, 16'h0005, 1'b0);
        @(negedge clock);
        check("post_midrst_addr", 32'(bus_address[0]), 32'h12355);
        wait_idle();

        // Randomized traffic with random bus backpressure
        ready_mode = 0;
        for (int n = 0; n < 80; n++) begin
            logic [15:0] s, b, i, d;
            s = ($urandom % 4 == 0) ? 16'hFFF0 | 16'($urandom % 16) : 16'($urandom);
            b = ($urandom % 3 == 0) ? 16'hFFFF - 16'($urandom % 4) : 16'($urandom);
            i = 16'($urandom);
            d = 16'($urandom);
            send(3'($urandom), s, b, i, d, 1'($urandom));
            if ($urandom % 4 == 0) begin
                repeat ($urandom % 3) @(posedge clock);
                #1;
            end
        end
        ready_mode = 1;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
